ram_wb_sc_ctrl: RTL and testbench

- Wishbone B3 slave front-end that drives a single-port, single-clock, word-addressed synchronous RAM.
- The RAM has one read-latency cycle and no byte enables. This block converts byte-addressed WB accesses into RAM word accesses.
- It performs read-modify-write (RMW) for partial-byte writes and generates pipelined addresses for incrementing and wrapping read bursts.
- Sits between the WB arbiter/interconnect and the RAM array.

---
 rtl/ram_wb_sc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ram_wb_sc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_sc_ctrl.sv
// Wishbone B3 slave front-end for a single-port, one-cycle-latency word RAM.
// Converts byte-addressed WB accesses into RAM word accesses. Partial-byte
// writes become a read-modify-write. Incrementing and wrapping read bursts
// get pipelined RAM addresses, so a burst can deliver one beat per cycle.
//
// Handshake: a request is wb_cyc_i & wb_stb_i. The slave completes a request
// by asserting exactly one of wb_ack_o / wb_err_o for one cycle. While stb is
// low inside a read burst, the RAM address is held so the data stays valid.
// wb_dat_o is only meaningful while wb_ack_o is high.
module ram_wb_sc_ctrl #(
  parameter int wb_adr_width  = 24,
  parameter int ram_adr_width = 22,
  parameter int mem_size      = 262144
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic [wb_adr_width-1:0]  wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ram_adr_width-1:0] ram_adr_o,
  output logic [31:0]              ram_dat_o,
  output logic                     ram_we_o,
  input  logic [31:0]              ram_dat_i,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RMW  = 3'd2,
    S_WACK = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ram_adr_width-1:0] addr_q, addr_d;
  logic [31:0]              dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;

  logic                     req;
  logic [ram_adr_width-1:0] wb_word;
  logic [ram_adr_width-1:0] next_addr;
  logic                     rd_ack, rd_err;
  logic                     cti_end;
  logic [31:0]              merged;
  logic                     unused_adr_lsb;

  function automatic logic in_range(input logic [ram_adr_width-1:0] a);
    return 64'(a) < 64'(mem_size);
  endfunction

  assign req            = wb_cyc_i & wb_stb_i;
  assign wb_word        = wb_adr_i[wb_adr_width-1:2];
  assign unused_adr_lsb = ^wb_adr_i[1:0];
  assign cti_end        = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b111);
  assign rd_ack         = (state_q == S_RD) && req && in_range(addr_q);
  assign rd_err         = (state_q == S_RD) && req && !in_range(addr_q);
  assign wb_dat_o       = ram_dat_i;
  assign dbg_state_o    = state_q;

  // Burst address successor: linear wraps the whole space, wrapN only the low bits.
  always_comb begin
    next_addr = addr_q + ram_adr_width'(1);
    case (wb_bte_i)
      2'b01:   next_addr = {addr_q[ram_adr_width-1:2], addr_q[1:0] + 2'd1};
      2'b10:   next_addr = {addr_q[ram_adr_width-1:3], addr_q[2:0] + 3'd1};
      2'b11:   next_addr = {addr_q[ram_adr_width-1:4], addr_q[3:0] + 4'd1};
      default: ;
    endcase
  end

  // Byte merge of the latched write data over the word just read from RAM.
  always_comb begin
    merged = ram_dat_i;
    for (int b = 0; b < 4; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!in_range(wb_word))     state_d = S_ERR;
          else if (!wb_we_i)          state_d = S_RD;
          else if (wb_sel_i == 4'hF)  state_d = S_WACK;
          else                        state_d = S_RMW;
        end
      end
      S_RD: begin
        if (!wb_cyc_i)                          state_d = S_IDLE;
        else if ((rd_ack || rd_err) && cti_end) state_d = S_IDLE;
      end
      S_RMW:   state_d = S_WACK;
      S_WACK:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture the request in IDLE, advance on read beats.
  always_comb begin
    addr_d = addr_q;
    dat_d  = dat_q;
    sel_d  = sel_q;
    case (state_q)
      S_IDLE: begin
        if (req && in_range(wb_word)) begin
          addr_d = wb_word;
          dat_d  = wb_dat_i;
          sel_d  = wb_sel_i;
        end
      end
      S_RD: begin
        if (rd_ack || rd_err) addr_d = next_addr;
      end
      default: ;
    endcase
  end

  // Outputs per state; reset forces all strobes low regardless of WB inputs.
  always_comb begin
    ram_adr_o = addr_q;
    ram_dat_o = wb_dat_i;
    ram_we_o  = 1'b0;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ram_adr_o = wb_word;
        ram_we_o  = req && in_range(wb_word) && wb_we_i && (wb_sel_i == 4'hF);
      end
      S_RD: begin
        wb_ack_o  = rd_ack;
        wb_err_o  = rd_err;
        ram_adr_o = (rd_ack || rd_err) ? next_addr : addr_q;
      end
      S_RMW: begin
        ram_dat_o = merged;
        ram_we_o  = 1'b1;
      end
      S_WACK:  wb_ack_o = 1'b1;
      S_ERR:   wb_err_o = 1'b1;
      default: ;
    endcase
    if (!wb_rst_n_i) begin
      ram_we_o = 1'b0;
      wb_ack_o = 1'b0;
      wb_err_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_wb_sc_ctrl.sv
// Testbench for ram_wb_sc_ctrl: behavioural RAM, directed scenarios plus
// randomized single accesses and bursts, scoreboard with an expected queue.
module tb_ram_wb_sc_ctrl;

  localparam int AW  = 24;
  localparam int RAW = 22;
  localparam int MEM = 262144;

  logic           clk, rst_n;
  logic [AW-1:0]  wb_adr;
  logic [31:0]    wb_dat_w, wb_dat_r;
  logic [3:0]     wb_sel;
  logic           wb_we, wb_cyc, wb_stb;
  logic [2:0]     wb_cti;
  logic [1:0]     wb_bte;
  logic           wb_ack, wb_err;
  logic [RAW-1:0] ram_adr;
  logic [31:0]    ram_dat_w, ram_dat_r;
  logic           ram_we;
  logic [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  // expected entry: [33]=err expected, [32]=compare data, [31:0]=data
  logic [33:0] exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] mem[0:MEM-1];

  ram_wb_sc_ctrl #(.wb_adr_width(AW), .ram_adr_width(RAW), .mem_size(MEM)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_cti_i(wb_cti), .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
    .wb_err_o(wb_err), .ram_adr_o(ram_adr), .ram_dat_o(ram_dat_w), .ram_we_o(ram_we),
    .ram_dat_i(ram_dat_r), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset-independent infrastructure ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we && ram_adr < RAW'(MEM)) mem[ram_adr] <= ram_dat_w;
    ram_dat_r <= (ram_adr < RAW'(MEM)) ? mem[ram_adr] : 32'h0;
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEAD_BEEF;
    if (i == 8) return 32'hAABB_CCDD;
    return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (wb_ack || wb_err) begin
        checks++;
        if (wb_ack && wb_err) begin
          errors++;
          $display("FAIL ack_err_both: got ack=1 err=1 expected only one");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb_ack, wb_err);
        end else begin
          e = exp_q.pop_front();
          if (e[33] != wb_err) begin
            errors++;
            $display("FAIL resp_kind: got err=%0b expected err=%0b", wb_err, e[33]);
          end else if (e[32]) begin
            checks++;
            if (wb_dat_r !== e[31:0]) begin
              errors++;
              $display("FAIL rd_data: got %h expected %h", wb_dat_r, e[31:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_cti = 3'b000; wb_bte = 2'b00;
  endtask

  task automatic wb_single(input logic we, input logic [RAW-1:0] word,
                           input logic [31:0] dat, input logic [3:0] sel);
    int lat, we0, exp_lat;
    logic we_first, in_rng;
    logic [31:0] nw;
    in_rng = (int'(word) < MEM);
    if (!in_rng) exp_q.push_back({1'b1, 1'b0, 32'h0});
    else if (!we) exp_q.push_back({1'b0, 1'b1, ref_rd(int'(word))});
    else begin
      nw = ref_rd(int'(word));
      for (int b = 0; b < 4; b++) if (sel[b]) nw[8*b +: 8] = dat[8*b +: 8];
      ref_mem[int'(word)] = nw;
      exp_q.push_back({1'b0, 1'b0, 32'h0});
    end
    we0 = we_cnt;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = {word, 2'b00};
    wb_dat_w = dat; wb_sel = sel; wb_cti = 3'b000; wb_bte = 2'b00;
    lat = 0;
    @(negedge clk);
    we_first = ram_we;
    while (!(wb_ack || wb_err) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = (in_rng && we && sel != 4'hF) ? 2 : 1;
    check(we ? "wr_latency" : "rd_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    bus_idle();
    check("we_in_req_cycle", 64'(we_first), 64'(in_rng && we && sel == 4'hF));
    check("we_pulses", 64'(we_cnt - we0), 64'(in_rng && we));
  endtask

  function automatic int beat_word(input int start, input logic [1:0] bte, input int i);
    int n, base;
    if (bte == 2'b00) return (start + i) % (1 << RAW);
    n = 4 << (int'(bte) - 1);
    base = start - (start % n);
    return base + ((start % n) + i) % n;
  endfunction

  task automatic wb_burst(input int start, input logic [1:0] bte, input int nbeats,
                          input int pause_after);
    int lat, w;
    for (int i = 0; i < nbeats; i++) begin
      w = beat_word(start, bte, i);
      if (w >= MEM) exp_q.push_back({1'b1, 1'b0, 32'h0});
      else exp_q.push_back({1'b0, 1'b1, ref_rd(w)});
    end
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_sel = 4'hF; wb_bte = bte;
    wb_adr = AW'(start) << 2;
    wb_cti = (nbeats == 1) ? 3'b111 : 3'b010;
    for (int i = 0; i < nbeats; i++) begin
      lat = 0;
      @(negedge clk);
      while (!(wb_ack || wb_err) && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      check("beat_latency", 64'(lat), (i == 0) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      if (i == nbeats - 1) break;
      if (i == pause_after) begin
        wb_stb = 0;
        repeat (2) @(posedge clk);
        #1;
        wb_stb = 1;
      end
      wb_cti = (i + 1 == nbeats - 1) ? 3'b111 : 3'b010;
      wb_adr = AW'(beat_word(start, bte, i + 1)) << 2;
    end
    bus_idle();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int we0, wd, nb, p;
    logic [31:0] old9;
    for (int i = 0; i < 512; i++) begin
      mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    for (int i = MEM - 16; i < MEM; i++) begin
      mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset held with an active full-word write request on the bus.
    rst_n = 0;
    bus_idle();
    wb_adr = '0; wb_dat_w = 32'hFFFF_FFFF; wb_sel = 4'hF;
    #2;
    wb_cyc = 1; wb_stb = 1; wb_we = 1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_err", 64'(wb_err), 64'd0);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    bus_idle();
    @(posedge clk); #1;
    rst_n = 1;

    // Classic read of preloaded word 5.
    wb_single(0, 22'd5, 32'h0, 4'hF);
    check("state_idle_after_read", 64'(dbg_state), 64'd0);

    // Partial write RMW on word 8, then read back.
    wb_single(1, 22'd8, 32'h1122_3344, 4'b0101);
    check("ref_rmw_word8", 64'(ref_rd(8)), 64'h0000_0000_AA22_CC44);
    wb_single(0, 22'd8, 32'h0, 4'hF);

    // Full write to byte address 0x20 (word 8), then read back.
    wb_single(1, 22'd8, 32'h1234_5678, 4'hF);
    wb_single(0, 22'd8, 32'h0, 4'hF);

    // Wrap4 burst from word 6 with a 2-cycle stb drop after beat 2.
    wb_burst(6, 2'b01, 4, 1);
    check("state_idle_after_burst", 64'(dbg_state), 64'd0);

    // Out-of-range read and write at word 262144, and at the top word.
    wb_single(0, 22'(MEM), 32'h0, 4'hF);
    wb_single(1, 22'(MEM), 32'hCAFE_F00D, 4'hF);
    wb_single(1, 22'h3F_FFFF, 32'hCAFE_F00D, 4'b0010);

    // Linear burst running past the last implemented word.
    wb_burst(MEM - 2, 2'b00, 4, -1);

    // Reset asserted during the RMW cycle.
    old9 = ref_rd(9);
    we0 = we_cnt;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = {22'd9, 2'b00};
    wb_dat_w = 32'h0BAD_0BAD; wb_sel = 4'b0011;
    @(posedge clk); #2;
    check("rmw_we_high", 64'(ram_we), 64'd1);
    rst_n = 0;
    #1;
    check("rst_mid_rmw_we", 64'(ram_we), 64'd0);
    check("rst_mid_rmw_ack", 64'(wb_ack), 64'd0);
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check("rst_mid_rmw_we_pulses", 64'(we_cnt - we0), 64'd0);
    wb_single(0, 22'd9, 32'h0, 4'hF);
    check("ref_word9_unchanged", 64'(ref_rd(9)), 64'(old9));

    // Randomized single accesses.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) wd = $urandom_range(MEM, (1 << RAW) - 1);
      else wd = $urandom_range(0, 255);
      wb_single(1'($urandom_range(0, 1)), RAW'(wd), $urandom, 4'($urandom_range(0, 15)));
    end

    // Randomized bursts.
    for (int k = 0; k < 12; k++) begin
      nb = $urandom_range(1, 8);
      p  = int'($urandom_range(0, nb)) - 1;
      if (p >= nb - 1) p = -1;
      wb_burst($urandom_range(0, 255), 2'($urandom_range(0, 3)), nb, p);
    end

    // Drain the scoreboard.
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
